// File: rtl/video_timing_gen.sv
// Raster timing generator: coordinate counters, active/sync decode and a programmable
// delay line that aligns hsync/vsync/vde with the downstream pixel pipeline.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned H_FP       = 110,
    parameter int unsigned H_SYNC     = 40,
    parameter int unsigned H_BP       = 220,
    parameter int unsigned V_ACTIVE   = 720,
    parameter int unsigned V_FP       = 5,
    parameter int unsigned V_SYNC     = 5,
    parameter int unsigned V_BP       = 20,
    parameter bit          HSYNC_POL  = 1'b1,
    parameter bit          VSYNC_POL  = 1'b1,
    parameter int unsigned SYNC_DELAY = 3
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        active,
    output logic [10:0] x_coord,
    output logic [9:0]  y_coord,
    output logic        hsync,
    output logic        vsync,
    output logic        vde,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam logic [10:0] L_H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] L_HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] L_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] L_H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  L_V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  L_VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  L_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  L_V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    // {hsync, vsync, de} when nothing is being displayed
    localparam logic [2:0]  L_IDLE_SYNC = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

    typedef enum logic {StIdle, StRun} state_t;

    state_t      r_state;
    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic        r_active;
    logic        r_frame_start;
    logic [15:0] r_frame_count;
    logic [2:0]  r_dly [SYNC_DELAY+1];

    logic [10:0] w_x_nxt;
    logic [9:0]  w_y_nxt;
    logic        w_fs_nxt;
    logic        w_wrap;
    logic        w_act_nxt;
    logic        w_hs_raw;
    logic        w_vs_raw;

    // Decodes use the next-state counters so they line up with the registered coordinates.
    always_comb begin
        w_x_nxt  = '0;
        w_y_nxt  = '0;
        w_fs_nxt = 1'b0;
        w_wrap   = 1'b0;
        if (run) begin
            if (r_state == StIdle) begin
                w_fs_nxt = 1'b1;
            end else if (r_x == L_H_LAST) begin
                if (r_y == L_V_LAST) begin
                    w_fs_nxt = 1'b1;
                    w_wrap   = 1'b1;
                end else begin
                    w_y_nxt = r_y + 10'd1;
                end
            end else begin
                w_x_nxt = r_x + 11'd1;
                w_y_nxt = r_y;
            end
        end
        w_act_nxt = run && (w_x_nxt < L_H_ACT) && (w_y_nxt < L_V_ACT);
        w_hs_raw  = (run && (w_x_nxt >= L_HS_BEG) && (w_x_nxt < L_HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        w_vs_raw  = (run && (w_y_nxt >= L_VS_BEG) && (w_y_nxt < L_VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_x           <= '0;
            r_y           <= '0;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= run ? StRun : StIdle;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_active      <= w_act_nxt;
            r_frame_start <= w_fs_nxt;
            if (w_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // Stage 0 is coincident with the coordinates; the outputs tap stage SYNC_DELAY.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= SYNC_DELAY; i++) begin
                r_dly[i] <= L_IDLE_SYNC;
            end
        end else begin
            r_dly[0] <= {w_hs_raw, w_vs_raw, w_act_nxt};
            for (int unsigned i = 1; i <= SYNC_DELAY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign x_coord     = r_x;
    assign y_coord     = r_y;
    assign active      = r_active;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;
    assign hsync       = r_dly[SYNC_DELAY][2];
    assign vsync       = r_dly[SYNC_DELAY][1];
    assign vde         = r_dly[SYNC_DELAY][0];

endmodule
